kmean_mul_pipe: RTL and testbench

Parametrised, pipelined multiplier with valid/ready flow control, per-transaction signed/unsigned mode and tag pass-through. It replaces the fixed-width combinational distance-multiply units in the k-means datapath. It sits between the point-stream unpacker and the distance accumulator, so backpressure from the accumulator stalls the multiplier without losing products.

---
 rtl/kmean_mul_pipe.sv | 125 ++++++++++++
 tb/tb_kmean_mul_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmean_mul_pipe.sv
// Pipelined signed/unsigned multiplier with tag pass-through; NUM_STAGE cycles latency, one beat/cycle.
// Whole pipe stalls when out_valid && !out_ready. KMEAN_MUL_SAT_EN enables saturation when P_WIDTH < A_WIDTH+B_WIDTH.
module kmean_mul_pipe #(
   parameter int A_WIDTH   = 7,
   parameter int B_WIDTH   = 10,
   parameter int P_WIDTH   = 17,
   parameter int NUM_STAGE = 3,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [B_WIDTH-1:0]   in_b,
   input  logic                 in_signed,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [P_WIDTH-1:0]   out_p,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_sat
);

   localparam int W  = A_WIDTH + B_WIDTH;
   localparam int LW = (P_WIDTH > W) ? P_WIDTH : W;

   logic                 adv;
   logic [LW-1:0]        a_l;
   logic [LW-1:0]        b_l;
   logic [P_WIDTH-1:0]   res_c;
   logic [NUM_STAGE-1:0] vld;
   logic [P_WIDTH-1:0]   p_q   [NUM_STAGE];
   logic [TAG_WIDTH-1:0] tag_q [NUM_STAGE];

   assign adv      = out_ready || !out_valid;
   assign in_ready = adv && !reset;

   // Extending to LW (not just W) makes the LW-bit product already the
   // sign/zero-extended exact product, so the wide case needs no extra step.
   assign a_l = {{(LW-A_WIDTH){in_signed & in_a[A_WIDTH-1]}}, in_a};
   assign b_l = {{(LW-B_WIDTH){in_signed & in_b[B_WIDTH-1]}}, in_b};

`ifdef KMEAN_MUL_SAT_EN
   logic                 sat_c;
   logic [NUM_STAGE-1:0] sat_q;
`endif

   generate
      if (P_WIDTH < W) begin : g_narrow
`ifdef KMEAN_MUL_SAT_EN
         logic [LW-1:0] prod;
         logic          ovf;

         assign prod = a_l * b_l;

         always_comb begin
            ovf   = 1'b0;
            res_c = prod[P_WIDTH-1:0];
            if (in_signed) begin
               // In range only if all bits from the result sign bit upward agree.
               ovf = !((&prod[LW-1:P_WIDTH-1]) || !(|prod[LW-1:P_WIDTH-1]));
               if (ovf)
                  res_c = prod[LW-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                     : {1'b0, {(P_WIDTH-1){1'b1}}};
            end else begin
               ovf = |prod[LW-1:P_WIDTH];
               if (ovf)
                  res_c = '1;
            end
         end

         assign sat_c = ovf;
`else
         assign res_c = P_WIDTH'(a_l * b_l);
`endif
      end else begin : g_wide
         assign res_c = a_l * b_l;
`ifdef KMEAN_MUL_SAT_EN
         assign sat_c = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (adv) begin
         vld[0] <= in_valid;
         for (int i = 1; i < NUM_STAGE; i++)
            vld[i] <= vld[i-1];
      end
   end

   // Payload registers are not reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (adv) begin
         p_q[0]   <= res_c;
         tag_q[0] <= in_tag;
         for (int i = 1; i < NUM_STAGE; i++) begin
            p_q[i]   <= p_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

`ifdef KMEAN_MUL_SAT_EN
   always_ff @(posedge clk) begin
      if (adv) begin
         sat_q[0] <= sat_c;
         for (int i = 1; i < NUM_STAGE; i++)
            sat_q[i] <= sat_q[i-1];
      end
   end

   assign out_sat = out_valid & sat_q[NUM_STAGE-1];
`else
   assign out_sat = 1'b0;
`endif

   assign out_valid = vld[NUM_STAGE-1];
   assign out_p     = out_valid ? p_q[NUM_STAGE-1]   : '0;
   assign out_tag   = out_valid ? tag_q[NUM_STAGE-1] : '0;

endmodule

// File: tb/tb_kmean_mul_pipe.sv
// Bench for kmean_mul_pipe: default-width instance plus a P_WIDTH=12 instance sharing one stimulus stream.
// Expected behaviour of the narrow instance follows KMEAN_MUL_SAT_EN when defined.
module tb_kmean_mul_pipe;

   typedef struct {
      logic [6:0]  a;
      logic [9:0]  b;
      logic        s;
      logic [4:0]  tag;
      logic [16:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0]  tag;
      logic [16:0] p17;
      logic [11:0] p12;
      logic        sat12;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [6:0]  in_a = '0;
   logic [9:0]  in_b = '0;
   logic        in_signed = 1'b0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_sat;
   logic [16:0] out_p;
   logic [4:0]  out_tag;
   logic        u1_in_ready, u1_out_valid, u1_out_sat;
   logic [11:0] u1_out_p;
   logic [4:0]  u1_out_tag;

   logic        rand_bp = 1'b0;
   logic        ready_force = 1'b1;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_out = 0;
   exp_t        q[$];
   vec_t        tbl[8];

   kmean_mul_pipe #(.A_WIDTH(7), .B_WIDTH(10), .P_WIDTH(17), .NUM_STAGE(3), .TAG_WIDTH(5)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
      .out_tag(out_tag), .out_sat(out_sat));

   kmean_mul_pipe #(.A_WIDTH(7), .B_WIDTH(10), .P_WIDTH(12), .NUM_STAGE(3), .TAG_WIDTH(5)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u1_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(u1_out_valid), .out_ready(out_ready), .out_p(u1_out_p),
      .out_tag(u1_out_tag), .out_sat(u1_out_sat));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : ready_force;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Integer reference: exact product, then clamp or wrap to pw bits.
   function automatic logic [16:0] mdl_p(input logic [6:0] a, input logic [9:0] b,
                                         input logic s, input int pw, output logic sat);
      longint av, bv, pr, lim;
      av  = (s && a[6]) ? longint'(a) - 128  : longint'(a);
      bv  = (s && b[9]) ? longint'(b) - 1024 : longint'(b);
      pr  = av * bv;
      sat = 1'b0;
      lim = 0;
`ifdef KMEAN_MUL_SAT_EN
      if (pw < 17) begin
         if (s) begin
            lim = longint'(1) <<< (pw - 1);
            if (pr > lim - 1) begin pr = lim - 1; sat = 1'b1; end
            else if (pr < -lim) begin pr = -lim; sat = 1'b1; end
         end else begin
            lim = longint'(1) <<< pw;
            if (pr > lim - 1) begin pr = lim - 1; sat = 1'b1; end
         end
      end
`endif
      mdl_p = 17'(pr & ((longint'(1) <<< pw) - 1));
   endfunction

   task automatic send(input logic [6:0] a, input logic [9:0] b, input logic s,
                       input logic [4:0] t, input logic [16:0] e, output int waits);
      logic        sat12;
      logic [16:0] p12;
      in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      p12 = mdl_p(a, b, s, 12, sat12);
      q.push_back('{t, e, p12[11:0], sat12});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() != 0 && g < 200) begin
         @(posedge clk);
         g++;
      end
      #1;
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   logic        stall_prev = 1'b0;
   logic [16:0] hold_p;
   logic [11:0] hold_p12;
   logic [4:0]  hold_tag;
   logic        hold_sat;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_p",   64'(out_p),    64'(hold_p));
            chk("stall_tag", 64'(out_tag),  64'(hold_tag));
            chk("stall_sat", 64'(out_sat),  64'(hold_sat));
            chk("stall_p12", 64'(u1_out_p), 64'(hold_p12));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk("tag",     64'(out_tag),      64'(e.tag));
               chk("p17",     64'(out_p),        64'(e.p17));
               chk("sat17",   64'(out_sat),      64'd0);
               chk("valid12", 64'(u1_out_valid), 64'd1);
               chk("p12",     64'(u1_out_p),     64'(e.p12));
               chk("sat12",   64'(u1_out_sat),   64'(e.sat12));
               n_out++;
            end
         end
         stall_prev = out_valid && !out_ready;
         hold_p   = out_p;
         hold_p12 = u1_out_p;
         hold_tag = out_tag;
         hold_sat = out_sat;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, lat, mark;
      logic [6:0]  ra;
      logic [9:0]  rb;
      logic        rs, dsat;
      logic [16:0] re;

      tbl[0] = '{7'd127,  10'd1023,  1'b0, 5'd5, 17'd129921};
      tbl[1] = '{7'h40,   10'h3FF,   1'b1, 5'd1, 17'd64};
      tbl[2] = '{7'h40,   10'h1FF,   1'b1, 5'd2, 17'h18040};
      tbl[3] = '{7'd3,    10'd5,     1'b0, 5'd3, 17'd15};
      tbl[4] = '{7'h3F,   10'h200,   1'b1, 5'd4, 17'h18200};
      tbl[5] = '{7'h40,   10'h200,   1'b1, 5'd6, 17'h08000};
      tbl[6] = '{7'd0,    10'd1023,  1'b0, 5'd7, 17'd0};
      tbl[7] = '{7'h7F,   10'h3FF,   1'b1, 5'd8, 17'd1};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid),    64'd0);
      chk("rst_out_p",     64'(out_p),        64'd0);
      chk("rst_out_tag",   64'(out_tag),      64'd0);
      chk("rst_out_sat",   64'(out_sat),      64'd0);
      chk("rst_in_ready",  64'(in_ready),     64'd0);
      chk("rst_u1_ready",  64'(u1_in_ready),  64'd0);
      chk("rst_u1_valid",  64'(u1_out_valid), 64'd0);

      // First accept on first edge after release, then latency
      reset = 1'b0;
      #1;
      chk("ready_release", 64'(in_ready), 64'd1);
      send(tbl[0].a, tbl[0].b, tbl[0].s, tbl[0].tag, tbl[0].exp, w);
      chk("first_accept_wait", 64'(w), 64'd0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd3);
      drain();

      // Table vectors back to back
      for (int i = 0; i < 8; i++)
         send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, tbl[i].exp, w);
      drain();

      // Random backpressure stream, tags 0..19
      rand_bp = 1'b1;
      mark = n_out;
      for (int t = 0; t < 20; t++) begin
         ra = 7'($urandom);
         rb = 10'($urandom);
         rs = 1'($urandom);
         re = mdl_p(ra, rb, rs, 17, dsat);
         send(ra, rb, rs, 5'(t), re, w);
      end
      drain();
      rand_bp = 1'b0;
      chk("bp_count", 64'(n_out - mark), 64'd20);

      // Reset with a full pipe
      ready_force = 1'b0;
      @(posedge clk);
      #1;
      send(7'd10, 10'd20, 1'b0, 5'd21, 17'd200, w);
      send(7'd11, 10'd21, 1'b0, 5'd22, 17'd231, w);
      send(7'd12, 10'd22, 1'b0, 5'd23, 17'd264, w);
      chk("pipe_full_valid", 64'(out_valid), 64'd1);
      chk("pipe_full_ready", 64'(in_ready),  64'd0);
      reset = 1'b1;
      mark = n_out;
      @(posedge clk);
      #1;
      chk("midrst_valid",    64'(out_valid),    64'd0);
      chk("midrst_u1_valid", 64'(u1_out_valid), 64'd0);
      chk("midrst_p",        64'(out_p),        64'd0);
      chk("midrst_ready",    64'(in_ready),     64'd0);
      reset = 1'b0;
      ready_force = 1'b1;
      #1;
      chk("midrst_ready_release", 64'(in_ready), 64'd1);
      send(7'd127, 10'd1023, 1'b0, 5'd9, 17'd129921, w);
      chk("midrst_accept_wait", 64'(w), 64'd0);
      drain();
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_count", 64'(n_out - mark), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
